// File: rtl/fetch_pc_gen_if.sv
// Fetch address bus between the PC generator, the branch predictor and the I-cache.
// The master side is the PC generator; the slave side is its consumers and the backend.
interface fetch_pc_gen_if #(
  parameter int NUM_OF_FETCH = 4,
  parameter int VADDR_WIDTH  = 32
);
  logic                    stall_in;
  logic                    flush_in;
  logic [VADDR_WIDTH-1:0]  flush_target;
  logic [NUM_OF_FETCH-1:0] pred_taken;
  logic                    btb_upd_valid;
  logic [VADDR_WIDTH-1:0]  btb_upd_addr;
  logic [VADDR_WIDTH-1:0]  btb_upd_target;
  logic [VADDR_WIDTH-1:0]  first_instr_addr_cur;
  logic                    fetch_kill;
  logic                    pred_redirect;
  logic [VADDR_WIDTH-1:0]  pred_target;

  modport master (
    input  stall_in, flush_in, flush_target, pred_taken,
           btb_upd_valid, btb_upd_addr, btb_upd_target,
    output first_instr_addr_cur, fetch_kill, pred_redirect, pred_target
  );

  modport slave (
    output stall_in, flush_in, flush_target, pred_taken,
           btb_upd_valid, btb_upd_addr, btb_upd_target,
    input  first_instr_addr_cur, fetch_kill, pred_redirect, pred_target
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: sequential group addresses, direct-mapped BTB redirect on the
// predictor's taken bits one cycle after acceptance, and backend flush redirect.
module fetch_pc_gen #(
  parameter int NUM_OF_FETCH = 4,
  parameter int VADDR_WIDTH  = 32,
  parameter int BTB_ENTRIES  = 64,
  parameter logic [VADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input logic clock,
  input logic reset,
  fetch_pc_gen_if.master bus
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = VADDR_WIDTH - 2 - IDX_W;

  typedef logic [VADDR_WIDTH-1:0] addr_t;

  localparam addr_t STEP = addr_t'(4 * NUM_OF_FETCH);

  addr_t pc_q, pc_d;
  addr_t inflight_addr_q, inflight_addr_d;
  logic  inflight_valid_q, inflight_valid_d;
  logic  pend_q, pend_d;
  addr_t pend_target_q, pend_target_d;

  logic [BTB_ENTRIES-1:0] btb_valid_q;
  logic [TAG_W-1:0]       btb_tag_q    [BTB_ENTRIES];
  addr_t                  btb_target_q [BTB_ENTRIES];

  addr_t            lane_addr;
  logic [IDX_W-1:0] lane_idx;
  logic             redirect_now;
  addr_t            redirect_target;
  logic             kill_now;
  logic [IDX_W-1:0] upd_idx;

  // Scan lanes from highest to lowest so the lowest-index taken hit wins.
  always_comb begin
    redirect_now    = 1'b0;
    redirect_target = '0;
    lane_addr       = '0;
    lane_idx        = '0;
    for (int i = NUM_OF_FETCH - 1; i >= 0; i--) begin
      lane_addr = inflight_addr_q + addr_t'(4 * i);
      lane_idx  = lane_addr[2 +: IDX_W];
      if (bus.pred_taken[i] && btb_valid_q[lane_idx] &&
          btb_tag_q[lane_idx] == lane_addr[VADDR_WIDTH-1 -: TAG_W]) begin
        redirect_now    = 1'b1;
        redirect_target = btb_target_q[lane_idx];
      end
    end
    if (!inflight_valid_q || bus.flush_in) begin
      redirect_now    = 1'b0;
      redirect_target = '0;
    end
  end

  assign kill_now                 = pend_q | redirect_now;
  assign bus.first_instr_addr_cur = pc_q;
  assign bus.fetch_kill           = kill_now;
  assign bus.pred_redirect        = redirect_now;
  assign bus.pred_target          = redirect_target;

  // A redirect decided under stall is parked until the killed group is accepted.
  always_comb begin
    pc_d             = pc_q;
    pend_d           = pend_q;
    pend_target_d    = pend_target_q;
    inflight_addr_d  = inflight_addr_q;
    inflight_valid_d = 1'b0;
    if (bus.flush_in) begin
      pc_d   = bus.flush_target;
      pend_d = 1'b0;
    end else if (!bus.stall_in) begin
      inflight_addr_d  = pc_q;
      inflight_valid_d = !kill_now;
      pend_d           = 1'b0;
      if (pend_q)            pc_d = pend_target_q;
      else if (redirect_now) pc_d = redirect_target;
      else                   pc_d = pc_q + STEP;
    end else if (redirect_now) begin
      pend_d        = 1'b1;
      pend_target_d = redirect_target;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q             <= RESET_VECTOR;
      pend_q           <= 1'b0;
      pend_target_q    <= '0;
      inflight_addr_q  <= '0;
      inflight_valid_q <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      pend_q           <= pend_d;
      pend_target_q    <= pend_target_d;
      inflight_addr_q  <= inflight_addr_d;
      inflight_valid_q <= inflight_valid_d;
    end
  end

  assign upd_idx = bus.btb_upd_addr[2 +: IDX_W];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btb_valid_q <= '0;
    end else if (bus.btb_upd_valid) begin
      btb_valid_q[upd_idx] <= 1'b1;
    end
  end

  // Tag and target storage needs no reset; the valid bits gate every lookup.
  always_ff @(posedge clock) begin
    if (bus.btb_upd_valid) begin
      btb_tag_q[upd_idx]    <= bus.btb_upd_addr[VADDR_WIDTH-1 -: TAG_W];
      btb_target_q[upd_idx] <= bus.btb_upd_target;
    end
  end

endmodule

// File: doc/fetch_pc_gen.md
FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 SHALL have parameter NUM_OF_FETCH, default COMMON_PARAMS value, instructions per fetch group (4-byte instrs).
REQ-002 SHALL have parameter VADDR_WIDTH, default COMMON_PARAMS value, virtual address width.
REQ-003 SHALL have parameter BTB_ENTRIES, default 64, direct-mapped BTB depth (power of 2).
REQ-004 SHALL have parameter RESET_VECTOR, default 0, first fetch address after reset.
REQ-005 SHALL have port clock  in  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port stall_in  in  1  fetch stall; group on the bus is not accepted this cycle.
REQ-008 SHALL have port flush_in  in  1  backend redirect; highest priority.
REQ-009 SHALL have port flush_target  in  VADDR_WIDTH  redirect address, valid with flush_in.
REQ-010 SHALL have port pred_taken  in  NUM_OF_FETCH  predictor direction bits, per lane, for the group accepted the previous cycle.
REQ-011 SHALL have port btb_upd_valid  in  1  BTB write strobe from graduation.
REQ-012 SHALL have port btb_upd_addr  in  VADDR_WIDTH  branch instruction address.
REQ-013 SHALL have port btb_upd_target  in  VADDR_WIDTH  resolved taken target.
REQ-014 SHALL have port first_instr_addr_cur  out  VADDR_WIDTH  fetch group address to predictor and I-cache.
REQ-015 SHALL have port fetch_kill  out  1  group on the bus is wrong-path; consumers drop it.
REQ-016 SHALL have port pred_redirect  out  1  one-cycle pulse when a predicted-taken redirect is decided.
REQ-017 SHALL have port pred_target  out  VADDR_WIDTH  target of that redirect; valid with pred_redirect.

Function
REQ-018 Group SHALL be "accepted" in a cycle with !stall_in && !flush_in; while stall_in=1, first_instr_addr_cur and fetch_kill SHALL hold.
REQ-019 On acceptance of address A without pending redirect, next address SHALL be A + 4*NUM_OF_FETCH (wraps modulo 2^VADDR_WIDTH).
REQ-020 SHALL register accepted address and an inflight_valid flag (1 only if accepted group had fetch_kill=0); pred_taken SHALL be consumed only in the cycle after acceptance, only when inflight_valid=1.
REQ-021 BTB entry: valid bit, tag addr[VADDR_WIDTH-1 : 2+log2(BTB_ENTRIES)], target; index addr[2 +: log2(BTB_ENTRIES)].
REQ-022 Lane i address SHALL be inflight_addr + 4*i; lane hit = valid && tag match; candidate = pred_taken[i] && hit.
REQ-023 Redirect lane SHALL be lowest-index candidate; no candidate -> no redirect.
REQ-024 On redirect at cycle t: pred_redirect=1, pred_target=BTB target of chosen lane; group presented at t SHALL be marked fetch_kill=1 (held through stall); upon its acceptance next address SHALL be the target.
REQ-025 Killed group's prediction (arriving cycle after its acceptance) SHALL be ignored.
REQ-026 BTB write SHALL occur on btb_upd_valid, overwriting index unconditionally; lookup same cycle SHALL see pre-write contents.
REQ-027 flush_in SHALL, next cycle, present flush_target with fetch_kill=0, clear inflight_valid and pending redirect, and suppress pred_redirect in the flush cycle; flush overrides stall_in and prediction.
REQ-028 flush_in and btb_upd_valid in the same cycle SHALL both take effect.

Reset
REQ-029 On reset: first_instr_addr_cur=RESET_VECTOR, fetch_kill=0, pred_redirect=0, pred_target=0, inflight_valid=0, pending redirect cleared, all BTB valid bits 0.
REQ-030 Reset asserted mid-stall or mid-redirect SHALL discard all state; first group after release SHALL be RESET_VECTOR.

Verification (NUM_OF_FETCH=4, RESET_VECTOR=0x1000)
REQ-031 Release reset, stall 0, pred_taken 0 -> addresses 0x1000, 0x1010, 0x1020 on consecutive cycles, fetch_kill 0.
REQ-032 BTB write 0x1014->0x2000; accept 0x1010; next cycle pred_taken=0010 -> pred_redirect=1, pred_target=0x2000, bus 0x1020 with fetch_kill=1; next 0x2000, fetch_kill=0.
REQ-033 pred_taken=0010 with BTB empty -> no redirect, sequential 0x1020, 0x1030.
REQ-034 BTB hits lanes 1,2 (targets 0x3000, 0x4000), pred_taken=0110 -> pred_target=0x3000.
REQ-035 Redirect decided with stall_in=1 for 3 cycles -> killed address held 3 cycles, accepted, then target; flush_in target 0x8000 same cycle as redirect -> 0x8000 next, no pred_redirect.
REQ-036 Reset pulse during stall -> outputs at reset values immediately, 0x1000 after release, prior BTB entries miss.
